// File: rtl/matrix_frame_tx_pkg.sv
// Shared definitions for the matrix frame transmitter: default geometry,
// sample width, frame header byte and FSM state encoding.
package matrix_frame_tx_pkg;

   localparam int unsigned DEF_ROWS = 4;
   localparam int unsigned DEF_COLS = 4;
   localparam int unsigned DEF_DW   = 12;

   localparam logic [7:0] HDR_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA_HI,
      ST_DATA_LO,
      ST_CKSUM,
      ST_DONE
   } state_t;

endpackage

// File: rtl/matrix_sample_mem.sv
// Sample storage for the matrix scanner.
// Ports:
//   clk_i   - system clock (rising edge)
//   rst_i   - asynchronous active-low reset, clears every word
//   we_i    - write enable
//   waddr_i - write address
//   wdata_i - write data
//   raddr_i - read address (combinational read)
//   rdata_o - read data
module matrix_sample_mem #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned DW    = 12,
   parameter int unsigned AW    = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/matrix_frame_tx.sv
// Matrix frame transmitter: stores ADC samples addressed by row/column and,
// on end-of-scan, streams a frame to a byte-wide UART transmitter:
//   header A5, then for every word its upper byte and lower byte, then the
//   XOR of all data bytes.
// Ports:
//   clk_i, rst_i          - clock, asynchronous active-low reset
//   sample_valid_i        - sample strobe qualifying sample_i/row_i/col_i
//   sample_i, row_i, col_i- sample value and its matrix position
//   eos_i                 - end-of-scan strobe, starts a frame
//   tx_data_o, tx_valid_o - byte offered downstream
//   tx_ready_i            - downstream accepts the byte
//   busy_o                - frame in progress
//   frame_done_o          - one-cycle pulse after the last byte
//   overrun_o             - sticky: a sample or eos_i arrived while busy
module matrix_frame_tx
   import matrix_frame_tx_pkg::*;
#(
   parameter int unsigned ROWS = DEF_ROWS,
   parameter int unsigned COLS = DEF_COLS,
   parameter int unsigned DW   = DEF_DW
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          sample_valid_i,
   input  logic [DW-1:0] sample_i,
   input  logic [1:0]    row_i,
   input  logic [1:0]    col_i,
   input  logic          eos_i,
   output logic [7:0]    tx_data_o,
   output logic          tx_valid_o,
   input  logic          tx_ready_i,
   output logic          busy_o,
   output logic          frame_done_o,
   output logic          overrun_o
);

   localparam int unsigned DEPTH = ROWS * COLS;
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   state_t        state, state_nxt;
   logic [AW-1:0] idx;
   logic [7:0]    cksum;
   logic [DW-1:0] rd_word;
   logic [31:0]   row_w, col_w;
   logic          in_range, wr_en, hs;
   logic [AW-1:0] wr_addr;

   assign row_w    = 32'(row_i);
   assign col_w    = 32'(col_i);
   assign in_range = (row_w < ROWS) && (col_w < COLS);
   assign wr_addr  = AW'(row_w * COLS + col_w);
   assign wr_en    = sample_valid_i && in_range && (state == ST_IDLE);

   matrix_sample_mem #(
      .DEPTH (DEPTH),
      .DW    (DW),
      .AW    (AW)
   ) u_mem (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (wr_en),
      .waddr_i (wr_addr),
      .wdata_i (sample_i),
      .raddr_i (idx),
      .rdata_o (rd_word)
   );

   assign hs           = tx_valid_o && tx_ready_i;
   assign busy_o       = (state != ST_IDLE);
   assign frame_done_o = (state == ST_DONE);

   // tx_data_o is a pure function of state, idx and storage; storage cannot
   // change outside IDLE, so the offered byte is stable across any stall.
   always_comb begin
      state_nxt  = state;
      tx_valid_o = 1'b0;
      tx_data_o  = '0;
      case (state)
         ST_IDLE: begin
            if (eos_i) state_nxt = ST_HDR;
         end
         ST_HDR: begin
            tx_valid_o = 1'b1;
            tx_data_o  = HDR_BYTE;
            if (tx_ready_i) state_nxt = ST_DATA_HI;
         end
         ST_DATA_HI: begin
            tx_valid_o = 1'b1;
            tx_data_o  = 8'(rd_word >> 8);
            if (tx_ready_i) state_nxt = ST_DATA_LO;
         end
         ST_DATA_LO: begin
            tx_valid_o = 1'b1;
            tx_data_o  = rd_word[7:0];
            if (tx_ready_i) state_nxt = (idx == LAST_IDX) ? ST_CKSUM : ST_DATA_HI;
         end
         ST_CKSUM: begin
            tx_valid_o = 1'b1;
            tx_data_o  = cksum;
            if (tx_ready_i) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= ST_IDLE;
         idx       <= '0;
         cksum     <= '0;
         overrun_o <= 1'b0;
      end else begin
         state <= state_nxt;

         case (state)
            ST_HDR: begin
               if (hs) begin
                  idx   <= '0;
                  cksum <= '0;
               end
            end
            ST_DATA_HI: begin
               if (hs) cksum <= cksum ^ tx_data_o;
            end
            ST_DATA_LO: begin
               if (hs) begin
                  cksum <= cksum ^ tx_data_o;
                  if (idx != LAST_IDX) idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase

         if (state == ST_IDLE) begin
            if (eos_i) overrun_o <= 1'b0;
         end else if (sample_valid_i || eos_i) begin
            overrun_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_matrix_frame_tx.sv
module tb_matrix_frame_tx;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        sample_valid_i;
   logic [11:0] sample_i;
   logic [1:0]  row_i;
   logic [1:0]  col_i;
   logic        eos_i;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i;
   logic        busy_o;
   logic        frame_done_o;
   logic        overrun_o;

   int total = 0;
   int bad   = 0;
   int done_cnt;
   int stall_bad;

   logic [7:0]  got  [$];
   logic [7:0]  expq [$];
   logic [11:0] model [16];

   matrix_frame_tx #(
      .ROWS (4),
      .COLS (4),
      .DW   (12)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .sample_valid_i (sample_valid_i),
      .sample_i       (sample_i),
      .row_i          (row_i),
      .col_i          (col_i),
      .eos_i          (eos_i),
      .tx_data_o      (tx_data_o),
      .tx_valid_o     (tx_valid_o),
      .tx_ready_i     (tx_ready_i),
      .busy_o         (busy_o),
      .frame_done_o   (frame_done_o),
      .overrun_o      (overrun_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int r, input int c, input logic [11:0] v);
      @(negedge clk_i);
      sample_valid_i = 1'b1;
      row_i          = 2'(r);
      col_i          = 2'(c);
      sample_i       = v;
      model[r*4+c]   = v;
      @(negedge clk_i);
      sample_valid_i = 1'b0;
   endtask

   task automatic send_eos();
      @(negedge clk_i);
      eos_i = 1'b1;
      @(negedge clk_i);
      eos_i = 1'b0;
   endtask

   // Accept bytes until 'limit' have been collected; the last accepted
   // byte's handshake completes on the posedge after return.
   task automatic run_frame(input bit rnd, input int limit);
      int         cyc = 0;
      bit         stall_prev = 1'b0;
      logic [7:0] prev = '0;
      while (got.size() < limit && cyc < 3000) begin
         @(negedge clk_i);
         cyc++;
         if (frame_done_o) done_cnt++;
         if (stall_prev && tx_data_o !== prev) stall_bad++;
         tx_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (tx_valid_o && tx_ready_i) got.push_back(tx_data_o);
         stall_prev = tx_valid_o && !tx_ready_i;
         prev       = tx_data_o;
      end
   endtask

   task automatic finish_frame();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         tx_ready_i = 1'b0;
         if (frame_done_o) done_cnt++;
      end
   endtask

   task automatic build_exp();
      logic [7:0] ck = '0;
      logic [7:0] hi, lo;
      expq = {};
      expq.push_back(8'hA5);
      for (int i = 0; i < 16; i++) begin
         hi = {4'h0, model[i][11:8]};
         lo = model[i][7:0];
         expq.push_back(hi);
         expq.push_back(lo);
         ck = ck ^ hi ^ lo;
      end
      expq.push_back(ck);
   endtask

   task automatic check_frame(input string tag);
      build_exp();
      chk({tag, "_len"}, got.size(), 34);
      for (int i = 0; i < 34 && i < got.size(); i++) begin
         chk($sformatf("%s_b%0d", tag, i), got[i], expq[i]);
      end
   endtask

   initial begin
      rst_i          = 1'b0;
      sample_valid_i = 1'b0;
      sample_i       = '0;
      row_i          = '0;
      col_i          = '0;
      eos_i          = 1'b0;
      tx_ready_i     = 1'b0;
      for (int i = 0; i < 16; i++) model[i] = '0;

      // reset state
      repeat (2) @(negedge clk_i);
      chk("rst_valid",   tx_valid_o,   1'b0);
      chk("rst_data",    tx_data_o,    8'h00);
      chk("rst_busy",    busy_o,       1'b0);
      chk("rst_done",    frame_done_o, 1'b0);
      chk("rst_overrun", overrun_o,    1'b0);
      rst_i = 1'b1;

      // all words 9B2, ready held high
      for (int i = 0; i < 16; i++) wr(i / 4, i % 4, 12'h9B2);
      send_eos();
      chk("hdr_valid", tx_valid_o, 1'b1);
      chk("hdr_data",  tx_data_o,  8'hA5);
      chk("hdr_busy",  busy_o,     1'b1);
      got = {}; done_cnt = 0;
      run_frame(1'b0, 34);
      finish_frame();
      check_frame("f1");
      chk("f1_b1_const",  got[1],  8'h09);
      chk("f1_b2_const",  got[2],  8'hB2);
      chk("f1_cksum",     got[33], 8'h00);
      chk("f1_done_cnt",  done_cnt, 1);
      chk("f1_idle_busy", busy_o,   1'b0);

      // same content, random backpressure
      got = {}; done_cnt = 0; stall_bad = 0;
      send_eos();
      run_frame(1'b1, 34);
      finish_frame();
      check_frame("f2");
      chk("f2_stall_stable", stall_bad, 0);
      chk("f2_done_cnt",     done_cnt,  1);

      // word0=ABC, rest zero
      wr(0, 0, 12'hABC);
      for (int i = 1; i < 16; i++) wr(i / 4, i % 4, 12'h000);
      got = {}; done_cnt = 0;
      send_eos();
      run_frame(1'b0, 34);
      finish_frame();
      check_frame("f3");
      chk("f3_b1",    got[1],  8'h0A);
      chk("f3_b2",    got[2],  8'hBC);
      chk("f3_cksum", got[33], 8'hB6);

      // overrun: sample in DATA_LO, eos in CKSUM
      got = {}; done_cnt = 0;
      send_eos();
      run_frame(1'b0, 2);
      @(negedge clk_i);
      tx_ready_i     = 1'b0;
      sample_valid_i = 1'b1;
      row_i          = 2'd0;
      col_i          = 2'd0;
      sample_i       = 12'h123;
      @(negedge clk_i);
      sample_valid_i = 1'b0;
      chk("ovr_after_sample", overrun_o, 1'b1);
      chk("ovr_lo_hold",      tx_data_o, 8'hBC);
      run_frame(1'b0, 33);
      @(negedge clk_i);
      tx_ready_i = 1'b0;
      eos_i      = 1'b1;
      @(negedge clk_i);
      eos_i = 1'b0;
      chk("ovr_cksum_busy", busy_o,    1'b1);
      chk("ovr_cksum_data", tx_data_o, 8'hB6);
      run_frame(1'b0, 34);
      finish_frame();
      check_frame("f4");
      chk("f4_overrun_sticky", overrun_o, 1'b1);
      chk("f4_done_cnt",       done_cnt,  1);
      got = {}; done_cnt = 0;
      send_eos();
      chk("f5_overrun_clr", overrun_o, 1'b0);
      run_frame(1'b0, 34);
      finish_frame();
      check_frame("f5");

      // reset mid-frame after the 5th byte
      got = {}; done_cnt = 0;
      send_eos();
      run_frame(1'b0, 5);
      @(negedge clk_i);
      tx_ready_i     = 1'b0;
      sample_valid_i = 1'b1;
      @(negedge clk_i);
      sample_valid_i = 1'b0;
      chk("mrst_pre_overrun", overrun_o, 1'b1);
      rst_i = 1'b0;
      for (int i = 0; i < 16; i++) model[i] = '0;
      #1;
      chk("mrst_valid",   tx_valid_o,   1'b0);
      chk("mrst_data",    tx_data_o,    8'h00);
      chk("mrst_busy",    busy_o,       1'b0);
      chk("mrst_done",    frame_done_o, 1'b0);
      chk("mrst_overrun", overrun_o,    1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         if (frame_done_o) done_cnt++;
      end
      chk("mrst_no_done", done_cnt, 0);
      rst_i = 1'b1;
      got = {}; done_cnt = 0;
      send_eos();
      run_frame(1'b0, 34);
      finish_frame();
      check_frame("f6");
      chk("f6_cksum", got[33], 8'h00);

      // sample and eos together in IDLE
      @(negedge clk_i);
      sample_valid_i = 1'b1;
      eos_i          = 1'b1;
      row_i          = 2'd3;
      col_i          = 2'd3;
      sample_i       = 12'hFFF;
      model[15]      = 12'hFFF;
      @(negedge clk_i);
      sample_valid_i = 1'b0;
      eos_i          = 1'b0;
      got = {}; done_cnt = 0;
      run_frame(1'b0, 34);
      finish_frame();
      check_frame("f7");
      chk("f7_hi_last", got[31], 8'h0F);
      chk("f7_lo_last", got[32], 8'hFF);
      chk("f7_cksum",   got[33], 8'hF0);
      chk("f7_overrun", overrun_o, 1'b0);
      chk("f7_done",    done_cnt,  1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/matrix_frame_tx.md
MATRIX_FRAME_TX -- requirements
Module: matrix_frame_tx

Interface
REQ-001 Parameter ROWS, default 4, number of matrix rows scanned per frame.
REQ-002 Parameter COLS, default 4, number of matrix columns scanned per frame.
REQ-003 Parameter DW, default 12, ADC sample width in bits; the design SHALL support DW from 9 to 16.
REQ-004 clk_i  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst_i  input  1  reset; asynchronous, active-low.
REQ-006 sample_valid_i  input  1  one-cycle strobe (ADC end-of-conversion) marking sample_i, row_i and col_i as valid.
REQ-007 sample_i  input  DW  ADC conversion result.
REQ-008 row_i  input  2  row index of the sample.
REQ-009 col_i  input  2  column index of the sample.
REQ-010 eos_i  input  1  one-cycle end-of-scan strobe requesting frame transmission.
REQ-011 tx_data_o  output  8  byte offered to the downstream UART transmitter.
REQ-012 tx_valid_o  output  1  tx_data_o is valid.
REQ-013 tx_ready_i  input  1  downstream accepts the byte when tx_valid_o and tx_ready_i are both high on the same edge.
REQ-014 busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-015 frame_done_o  output  1  one-cycle pulse after the final frame byte is accepted.
REQ-016 overrun_o  output  1  sticky flag set when a sample or eos_i is dropped.

Function
REQ-017 Storage SHALL be ROWS*COLS words of DW bits, addressed as row_i*COLS+col_i.
REQ-018 In IDLE, sample_valid_i SHALL write sample_i at that edge; a later write to the same address SHALL overwrite it.
REQ-019 Writes with row_i>=ROWS or col_i>=COLS SHALL be discarded, and overrun_o SHALL stay unchanged.
REQ-020 The FSM SHALL have states IDLE, HDR, DATA_HI, DATA_LO, CKSUM and DONE.
REQ-021 IDLE->HDR SHALL occur on eos_i, and tx_valid_o SHALL be high with tx_data_o=8'hA5 in the next cycle.
REQ-022 HDR->DATA_HI SHALL occur on handshake; the word index SHALL be set to 0.
REQ-023 In DATA_HI, tx_data_o SHALL be the zero-extended upper DW-8 bits of word[index]; DATA_HI->DATA_LO SHALL occur on handshake.
REQ-024 In DATA_LO, tx_data_o SHALL be bits [7:0] of word[index]; on handshake the FSM SHALL go to DATA_HI with index+1, or to CKSUM if index=ROWS*COLS-1.
REQ-025 In CKSUM, tx_data_o SHALL be the XOR of all data bytes sent in this frame, excluding the header; CKSUM->DONE SHALL occur on handshake.
REQ-026 In DONE, tx_valid_o SHALL be 0 and frame_done_o SHALL be 1 for one cycle; the FSM SHALL then return to IDLE.
REQ-027 tx_valid_o SHALL be high in HDR, DATA_HI, DATA_LO and CKSUM only; while tx_valid_o is high and tx_ready_i is low, tx_data_o SHALL be held stable.
REQ-028 A sample_valid_i or eos_i arriving outside IDLE SHALL be ignored and SHALL set overrun_o.
REQ-029 When sample_valid_i and eos_i occur together in IDLE, the sample SHALL be stored and included in the frame.
REQ-030 overrun_o SHALL clear on the eos_i that is accepted in IDLE, and the same event SHALL start transmission.
REQ-031 Storage contents SHALL persist across frames.

Reset
REQ-032 While rst_i=0, the FSM SHALL be in IDLE with index=0, checksum=0 and all storage words=0.
REQ-033 While rst_i=0, tx_data_o=8'h00, tx_valid_o=0, busy_o=0, frame_done_o=0 and overrun_o=0.
REQ-034 Reset asserted mid-frame SHALL abort the frame immediately, with no further bytes and no frame_done_o pulse.

Structure
REQ-035 A shared package SHALL hold the default ROWS, COLS and DW, HDR_BYTE=8'hA5, and the FSM state encoding.
REQ-036 Storage SHALL be a sub-module matrix_sample_mem with a synchronous write port and a combinational read port.

Verification
REQ-037 Scenario: all 16 samples written as 12'h9B2, then eos_i with tx_ready_i=1 -> bytes A5, then (09,B2)x16, then 00; frame_done_o pulses once.
REQ-038 Scenario: word0=12'hABC, all other words 0 -> bytes A5,0A,BC,(00,00)x15, checksum B6.
REQ-039 Scenario: tx_ready_i toggled randomly -> byte sequence identical to REQ-037 and tx_data_o stable during every stall.
REQ-040 Scenario: sample_valid_i during DATA_LO, and a second eos_i during CKSUM -> overrun_o=1, frame content unchanged, overrun_o clears on the next eos_i.
REQ-041 Scenario: rst_i pulsed low after the 5th byte -> tx_valid_o=0 at once, no frame_done_o, all outputs at reset values, and a subsequent frame returns all-zero data with checksum 00.
REQ-042 Scenario: sample_valid_i (row 3, col 3, 12'hFFF) and eos_i in the same cycle -> the last data bytes are 0F,FF.
